// File: rtl/fft_pkg.sv
// Helpers shared by the R2^2SDF butterfly stages: width math, butterfly mode
// codes and the round-half-up halving used by scaled stages.
package fft_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_BF   = 2'd1,
    MODE_ROT  = 2'd2
  } mode_e;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic mode_e bfii_mode(input logic sel, input logic tsel);
    if (!sel) return MODE_PASS;
    if (tsel) return MODE_BF;
    return MODE_ROT;
  endfunction

  // (v + 1) >>> 1 at a width that cannot overflow; callers truncate to their width.
  function automatic logic signed [63:0] round_shr1(input logic signed [63:0] v);
    return (v + 64'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/fft_r22sdf_bfii_stage_if.sv
// Sample-stream bundle for one BFII stage: valid/sync/data in, valid/first/data out.
interface fft_r22sdf_bfii_stage_if #(
  parameter int DW = 25,
  parameter int OW = 26
);
  logic                 valid_i;
  logic                 sync_i;
  logic signed [DW-1:0] x_re_i;
  logic signed [DW-1:0] x_im_i;
  logic                 valid_o;
  logic                 first_o;
  logic signed [OW-1:0] z_re_o;
  logic signed [OW-1:0] z_im_o;

  modport slave (
    input  valid_i, sync_i, x_re_i, x_im_i,
    output valid_o, first_o, z_re_o, z_im_o
  );

  modport master (
    output valid_i, sync_i, x_re_i, x_im_i,
    input  valid_o, first_o, z_re_o, z_im_o
  );
endinterface

// File: rtl/fft_cplx_delay_line.sv
// Complex shift register of DEPTH samples; shifts only when en_i is high.
// Output is the oldest entry, available combinationally.
module fft_cplx_delay_line #(
  parameter int W     = 26,
  parameter int DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic signed [W-1:0] d_re_i,
  input  logic signed [W-1:0] d_im_i,
  output logic signed [W-1:0] q_re_o,
  output logic signed [W-1:0] q_im_o
);
  logic signed [W-1:0] re_q [DEPTH];
  logic signed [W-1:0] im_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (en_i) begin
      re_q[0] <= d_re_i;
      im_q[0] <= d_im_i;
      for (int i = 1; i < DEPTH; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign q_re_o = re_q[DEPTH-1];
  assign q_im_o = im_q[DEPTH-1];
endmodule

// File: rtl/fft_r22sdf_bfii_stage.sv
// Self-sequencing R2^2SDF BFII stage (-j rotation butterfly, SR_LEN feedback).
// One registered output cycle; all state stalls while valid_i is low.
module fft_r22sdf_bfii_stage
  import fft_pkg::*;
#(
  parameter int DW     = 25,
  parameter int SR_LEN = 4,
  parameter int SCALE  = 0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fft_r22sdf_bfii_stage_if.slave io
);
  localparam int L  = clog2(SR_LEN);
  localparam int CW = L + 2;
  localparam int IW = DW + 1;
  localparam int OW = DW + 1 - SCALE;

  logic                 sync_hit;
  logic [CW-1:0]        cnt_q, cnt_d, idx;
  mode_e                mode;
  logic signed [IW-1:0] x_re, x_im, xsr_re, xsr_im;
  logic signed [IW-1:0] z_re, z_im, zsr_re, zsr_im;
  logic signed [OW-1:0] zo_re_d, zo_im_d, zo_re_q, zo_im_q;
  logic                 vld_q, first_d, first_q;

  assign sync_hit = io.valid_i && io.sync_i;
  assign idx      = sync_hit ? '0 : cnt_q;
  assign mode     = bfii_mode(idx[L], ~idx[L+1]);
  assign x_re     = {io.x_re_i[DW-1], io.x_re_i};
  assign x_im     = {io.x_im_i[DW-1], io.x_im_i};
  assign first_d  = io.valid_i && (idx == CW'(SR_LEN));

  always_comb begin
    cnt_d = cnt_q;
    if (io.valid_i) cnt_d = sync_hit ? CW'(1) : cnt_q + 1'b1;
  end

  always_comb begin
    z_re   = xsr_re;
    z_im   = xsr_im;
    zsr_re = x_re;
    zsr_im = x_im;
    case (mode)
      MODE_BF: begin
        z_re   = xsr_re + x_re;
        z_im   = xsr_im + x_im;
        zsr_re = xsr_re - x_re;
        zsr_im = xsr_im - x_im;
      end
      MODE_ROT: begin
        z_re   = xsr_re + x_im;
        z_im   = xsr_im - x_re;
        zsr_re = xsr_re - x_im;
        zsr_im = xsr_im + x_re;
      end
      default: ;
    endcase
  end

  generate
    if (SCALE != 0) begin : g_scale
      assign zo_re_d = OW'(round_shr1(64'(z_re)));
      assign zo_im_d = OW'(round_shr1(64'(z_im)));
    end else begin : g_grow
      assign zo_re_d = z_re;
      assign zo_im_d = z_im;
    end
  endgenerate

  fft_cplx_delay_line #(.W(IW), .DEPTH(SR_LEN)) u_sr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (io.valid_i),
    .d_re_i (zsr_re),
    .d_im_i (zsr_im),
    .q_re_o (xsr_re),
    .q_im_o (xsr_im)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      zo_re_q <= '0;
      zo_im_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      vld_q   <= io.valid_i;
      first_q <= first_d;
      if (io.valid_i) begin
        zo_re_q <= zo_re_d;
        zo_im_q <= zo_im_d;
      end
    end
  end

  assign io.valid_o = vld_q;
  assign io.first_o = first_q;
  assign io.z_re_o  = zo_re_q;
  assign io.z_im_o  = zo_im_q;
endmodule

// File: doc/fft_r22sdf_bfii_stage.md
Name: fft_r22sdf_bfii_stage

Overview:
- Self-sequencing R2²SDF BFII stage: the trivial -j rotation butterfly with a single-path delay feedback of SR_LEN complex samples.
- Generates its own sel/tsel from an internal sample counter, so upstream supplies only a valid strobe and a frame sync.
- Adds valid-gated stalling, a registered output, selectable growth-or-scale arithmetic and a frame-start marker.
- Sits between a BFI stage and the next twiddle multiplier in the pipelined FFT.

Parameters:
- DW, 25, input sample width per component (signed).
- SR_LEN, 4, feedback delay depth in samples; power of 2, at least 1.
- SCALE, 0, 0 = output grows to DW+1 bits; 1 = output is rounded >>1 and stays DW bits.
- OW, DW+1-SCALE, output width per component (derived; not to be overridden).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- valid_i  in  1  input sample strobe; all state advances only when high
- sync_i  in  1  with valid_i, marks the current input as frame index 0
- x_re_i  in  DW  input real part, signed
- x_im_i  in  DW  input imaginary part, signed
- valid_o  out  1  output sample strobe
- first_o  out  1  output sample is index 0 of an output frame
- z_re_o  out  OW  output real part, signed
- z_im_o  out  OW  output imaginary part, signed

Behaviour:
- Reset (async, rst_i=1): counter=0; all SR entries=0; valid_o=0; first_o=0; z_re_o=0; z_im_o=0.
- Counter: width L+2, where L=log2(SR_LEN). Increments modulo 4*SR_LEN on valid_i. If valid_i&&sync_i, the current sample uses index 0 and the counter loads 1.
- sync_i without valid_i: ignored.
- Effective index idx = (valid_i&&sync_i) ? 0 : cnt.
- sel = idx[L]; tsel = ~idx[L+1].
- Internal arithmetic: DW+1 bits, sign-extended. The SR is SR_LEN deep × (DW+1) bits per component. xsr = oldest SR entry.
- sel=0: z=xsr; zsr=x.
- sel=1, tsel=1 (plain butterfly): z=xsr+x; zsr=xsr-x.
- sel=1, tsel=0 (-j rotation): z_re=xsr_re+x_im; z_im=xsr_im-x_re; zsr_re=xsr_re-x_im; zsr_im=xsr_im+x_re.
- On valid_i: SR shifts, with zsr entering; the counter advances.
- On !valid_i: SR, counter and output data hold.
- Output register, 1-cycle latency:
  - valid_o <= valid_i.
  - z_*_o <= z when valid_i, else hold.
  - first_o <= valid_i && idx==SR_LEN.
- Scaling (SCALE=1): out = (z+1)>>>1, i.e. round half up, arithmetic shift.
- Scaling (SCALE=0): out = z at full DW+1 bits.
- No overflow is possible in either mode.
- Startup: the first SR_LEN valid outputs after reset are drained zeros with valid_o=1 and first_o=0.
- Steady state: each output frame lags its input frame by SR_LEN valid samples.
- Sync mid-frame: counter realigns immediately; SR is not cleared. The next SR_LEN outputs mix old and new frame data and are not flagged.
- Reset mid-frame: all state clears asynchronously. The first valid_i after release is index 0 with or without sync_i.

Decomposition:
- Package fft_pkg holds:
  - clog2 function;
  - the sel/tsel mode encoding constants (MODE_PASS, MODE_BF, MODE_ROT);
  - the rounding-shift function shared with BFI stages.
- One sub-module, fft_cplx_delay_line: a valid-gated, resettable SR_LEN × 2 × (DW+1) shift register. It is reusable by the BFI successor.
- Butterfly math and the counter stay in the top level.

Test Plan:
- DW=8, SR_LEN=2, SCALE=0; sync on x_re=1..8, x_im=0, continuous valid. Required outputs:
  - re/im pairs (0,0),(0,0),(4,0),(6,0),(-2,0),(-2,0),(5,-7),(6,-8);
  - then, on the next frame's first two inputs, (5,7),(6,8);
  - first_o high on the (4,0) sample.
- Same stimulus with SCALE=1. Required outputs:
  - (2,0),(3,0),(-1,0),(-1,0),(3,-3),(3,-4),(3,4),(3,4);
  - this confirms round half up.
- Same stimulus with valid_i deasserted for 3 cycles after every input. Required: an identical output sequence with valid_o gaps and held data.
- Reset asserted asynchronously mid-frame (between edges), then released. Required:
  - outputs and valid_o drop to 0 immediately;
  - the next frame starts at index 0;
  - 2 zero drain outputs follow.
- DW=8 extremes: x_re=-128 and x_im=127 in the rotation quarter, with SR holding -128. Required: z_re=-1, z_im=0 in 9 bits, with no wrap.
- sync_i pulsed with valid_i=0, then sync_i with valid_i at idx 5. Required: the first pulse is ignored; after the second, the counter reads 1 and the first_o position shifts accordingly.
